i2c_scl_clock: RTL and testbench

- SCL clock generator for the I2C master, instantiated by the master controller.
- Drives the open-drain SCL line low for the tLOW portion of each bit period and releases it for the tHIGH portion, exporting a phase counter that the master's data path uses to time SDA changes.
- Supports clock stretching by slaves and multi-master clock synchronisation.
- Detects a stuck-low bus and raises `bus_clear`.

---
 rtl/i2c_scl_clock_pkg.sv | 18 +
 rtl/i2c_stuck_low_detector.sv | 37 +++
 rtl/i2c_scl_clock.sv | 81 ++++++++
 tb/tb_i2c_scl_clock.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_scl_clock_pkg.sv
// Shared types and helpers for the I2C SCL clock generator.
package i2c_scl_clock_pkg;

    // Phase counter decision for one clk_in edge; the order of the values is the priority order.
    typedef enum logic [2:0] {
        PH_RELEASE,
        PH_HOLD,
        PH_RESTART,
        PH_WRAP,
        PH_ADVANCE
    } phase_act_e;

    // Only a definite 0 is low; a released or pulled-up line counts as high.
    function automatic logic line_is_low(input logic line);
        return (line === 1'b0);
    endfunction

endpackage

// File: rtl/i2c_stuck_low_detector.sv
// Counts consecutive low samples of SCL and flags a stuck-low bus.
module i2c_stuck_low_detector
    import i2c_scl_clock_pkg::*;
#(
    parameter int unsigned WAIT_WIDTH = 7,
    parameter int unsigned WAIT_END   = 99
) (
    input  logic clk_in,
    input  logic reset,
    input  logic scl_in,
    output logic bus_clear
);

    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(WAIT_END);

    logic [WAIT_WIDTH-1:0] wait_q;
    logic [WAIT_WIDTH-1:0] wait_d;

    // Saturating run length of low samples; any high sample clears it.
    always_comb begin
        wait_d = '0;
        if (line_is_low(scl_in)) begin
            wait_d = (wait_q == WAIT_LAST) ? wait_q : wait_q + WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign bus_clear = (wait_q == WAIT_LAST);

endmodule

// File: rtl/i2c_scl_clock.sv
// I2C master SCL generator: low/high phase counter with stretching,
// multi-master synchronisation and stuck-low detection.
module i2c_scl_clock
    import i2c_scl_clock_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH    = 3,
    parameter int unsigned COUNTER_END      = 4,
    parameter int unsigned COUNTER_HIGH     = 2,
    parameter int unsigned COUNTER_RISE     = 0,
    parameter int unsigned MULTI_MASTER     = 0,
    parameter int unsigned CLOCK_STRETCHING = 0,
    parameter int unsigned WAIT_WIDTH       = 7,
    parameter int unsigned WAIT_END         = 99
) (
    input  logic                     clk_in,
    input  logic                     reset,
    inout  wire                      scl,
    input  logic                     release_line,
    output logic                     bus_clear,
    output logic [COUNTER_WIDTH-1:0] counter
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_HIGH   = COUNTER_WIDTH'(COUNTER_HIGH);
    localparam logic [COUNTER_WIDTH-1:0] CNT_SETTLE = COUNTER_WIDTH'(COUNTER_HIGH + COUNTER_RISE);
    localparam logic [COUNTER_WIDTH-1:0] CNT_END    = COUNTER_WIDTH'(COUNTER_END);
    localparam bit STRETCH_EN = (CLOCK_STRETCHING != 0);
    localparam bit RESTART_EN = (MULTI_MASTER != 0) || (CLOCK_STRETCHING != 0);

    logic [COUNTER_WIDTH-1:0] counter_q;
    logic [COUNTER_WIDTH-1:0] counter_d;
    logic                     scl_low_c;
    logic                     drive_low_c;
    phase_act_e               act_c;

    always_comb begin
        scl_low_c   = line_is_low(scl);
        drive_low_c = (counter_q < CNT_HIGH) && !release_line;
        act_c       = PH_ADVANCE;
        counter_d   = counter_q + COUNTER_WIDTH'(1);

        if (release_line) begin
            act_c = PH_RELEASE;
        end else if (STRETCH_EN && scl_low_c &&
                     (counter_q >= CNT_HIGH) && (counter_q < CNT_SETTLE)) begin
            act_c = PH_HOLD;
        end else if (RESTART_EN && scl_low_c && (counter_q >= CNT_SETTLE)) begin
            // Someone else pulled SCL low after our release: start a fresh tLOW.
            act_c = PH_RESTART;
        end else if (counter_q == CNT_END) begin
            act_c = PH_WRAP;
        end

        case (act_c)
            PH_RELEASE, PH_RESTART, PH_WRAP: counter_d = '0;
            PH_HOLD:                         counter_d = counter_q;
            default:                         counter_d = counter_q + COUNTER_WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
        end else begin
            counter_q <= counter_d;
        end
    end

    assign scl     = drive_low_c ? 1'b0 : 1'bz;
    assign counter = counter_q;

    i2c_stuck_low_detector #(
        .WAIT_WIDTH (WAIT_WIDTH),
        .WAIT_END   (WAIT_END)
    ) u_stuck (
        .clk_in    (clk_in),
        .reset     (reset),
        .scl_in    (scl),
        .bus_clear (bus_clear)
    );

endmodule

// File: tb/tb_i2c_scl_clock.sv
// Bench for i2c_scl_clock: three parameterisations (free-run, multi-master+stretch,
// stretch with rise window) checked each cycle against a wired-AND bus model.
module tb_i2c_scl_clock;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       release_line;
    logic [2:0] ext_low;

    wire        scl_a, scl_b, scl_c;
    logic       bus_clear_a, bus_clear_b, bus_clear_c;
    logic [2:0] counter_a, counter_b, counter_c;

    pullup (scl_a);
    pullup (scl_b);
    pullup (scl_c);
    assign scl_a = ext_low[0] ? 1'b0 : 1'bz;
    assign scl_b = ext_low[1] ? 1'b0 : 1'bz;
    assign scl_c = ext_low[2] ? 1'b0 : 1'bz;

    always #2 clk_in = ~clk_in;

    i2c_scl_clock u_a (
        .clk_in(clk_in), .reset(reset), .scl(scl_a), .release_line(release_line),
        .bus_clear(bus_clear_a), .counter(counter_a)
    );

    i2c_scl_clock #(.MULTI_MASTER(1), .CLOCK_STRETCHING(1)) u_b (
        .clk_in(clk_in), .reset(reset), .scl(scl_b), .release_line(release_line),
        .bus_clear(bus_clear_b), .counter(counter_b)
    );

    i2c_scl_clock #(.CLOCK_STRETCHING(1), .COUNTER_RISE(1)) u_c (
        .clk_in(clk_in), .reset(reset), .scl(scl_c), .release_line(release_line),
        .bus_clear(bus_clear_c), .counter(counter_c)
    );

    // Reference model: period 5, low for counts 0..1, bus_clear after 99 low samples in a row.
    localparam int PER_END = 4;
    localparam int HIGH    = 2;
    localparam int STUCK   = 99;
    int mm_en[3]   = '{0, 1, 0};
    int cs_en[3]   = '{0, 1, 1};
    int rise_w[3]  = '{0, 0, 1};
    int m_cnt[3];
    int m_lowrun[3];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit bus_low(input int i);
        return ext_low[i] || (!release_line && m_cnt[i] < HIGH);
    endfunction

    function automatic int next_count(input int i, input bit low);
        int c = m_cnt[i];
        if (release_line) return 0;
        if (cs_en[i] != 0 && low && c >= HIGH && c < HIGH + rise_w[i]) return c;
        if ((mm_en[i] != 0 || cs_en[i] != 0) && low && c >= HIGH + rise_w[i]) return 0;
        return (c == PER_END) ? 0 : c + 1;
    endfunction

    function automatic logic [2:0] dut_cnt(input int i);
        return (i == 0) ? counter_a : (i == 1) ? counter_b : counter_c;
    endfunction

    function automatic logic dut_clr(input int i);
        return (i == 0) ? bus_clear_a : (i == 1) ? bus_clear_b : bus_clear_c;
    endfunction

    function automatic logic dut_scl(input int i);
        return (i == 0) ? scl_a : (i == 1) ? scl_b : scl_c;
    endfunction

    task automatic check_all(input string phase);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.cnt%0d", phase, i), 32'(dut_cnt(i)), 32'(m_cnt[i]));
            chk($sformatf("%s.clr%0d", phase, i), 32'(dut_clr(i)), 32'(m_lowrun[i] >= STUCK));
            chk($sformatf("%s.scl%0d", phase, i), 32'(dut_scl(i)), 32'(!bus_low(i)));
        end
    endtask

    // One clk_in cycle: model samples the bus at the rising edge, outputs checked on the falling edge.
    task automatic tick(input string phase);
        int nc[3];
        int nr[3];
        for (int i = 0; i < 3; i++) begin
            bit low = bus_low(i);
            nc[i] = next_count(i, low);
            nr[i] = low ? m_lowrun[i] + 1 : 0;
        end
        @(posedge clk_in);
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]    = nc[i];
            m_lowrun[i] = nr[i];
        end
        @(negedge clk_in);
        check_all(phase);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]    = 0;
            m_lowrun[i] = 0;
        end
    endtask

    initial begin
        int waited;
        reset        = 1'b1;
        release_line = 1'b0;
        ext_low      = '0;
        model_reset();

        // Reset state: counter 0 drives SCL low, no bus_clear.
        #1;
        check_all("reset");
        @(negedge clk_in);
        reset = 1'b0;

        // Free-run, no other master.
        repeat (15) tick("free");

        // Random foreign lows and occasional release_line.
        repeat (200) begin
            ext_low      = 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            release_line = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        ext_low      = '0;
        release_line = 1'b0;
        repeat (6) tick("settle");

        // Stuck low on every bus, applied while counter is in the low phase.
        waited = 0;
        while (m_cnt[1] != 0 && waited < 10) begin
            tick("align0");
            waited++;
        end
        chk("align0.found", 32'(counter_b), 32'd0);
        ext_low = 3'b111;
        repeat (110) tick("stuck");
        chk("stuck.bus_clear_b", 32'(bus_clear_b), 32'd1);
        ext_low = '0;
        tick("unstuck");
        chk("unstuck.bus_clear_b", 32'(bus_clear_b), 32'd0);
        repeat (4) tick("unstuck");

        // Multi-master restart exactly at the first high count (no rise window).
        waited = 0;
        while (m_cnt[1] != HIGH && waited < 10) begin
            tick("align2");
            waited++;
        end
        chk("align2.found", 32'(counter_b), 32'(HIGH));
        ext_low[1] = 1'b1;
        tick("mm");
        chk("mm.restart", 32'(counter_b), 32'd0);
        ext_low[1] = 1'b0;
        tick("mm");
        chk("mm.low1", 32'(scl_b), 32'd0);
        tick("mm");
        chk("mm.high", 32'(scl_b), 32'd1);

        // Stretch hold inside the rise window.
        waited = 0;
        while (m_cnt[2] != HIGH && waited < 10) begin
            tick("align_c");
            waited++;
        end
        ext_low[2] = 1'b1;
        repeat (2) tick("hold");
        chk("hold.count", 32'(counter_c), 32'(HIGH));
        ext_low[2] = 1'b0;
        repeat (3) tick("hold_rel");

        // release_line keeps SCL released and counters at 0.
        release_line = 1'b1;
        repeat (8) tick("release");
        chk("release.scl_a", 32'(scl_a), 32'd1);
        release_line = 1'b0;
        #1;
        chk("release.low_starts", 32'(scl_a), 32'd0);
        repeat (8) tick("unrelease");

        // Reset in the middle of the high phase.
        waited = 0;
        while (m_cnt[0] < HIGH + 1 && waited < 10) begin
            tick("align_rst");
            waited++;
        end
        reset = 1'b1;
        model_reset();
        #1;
        check_all("midreset");
        @(negedge clk_in);
        check_all("midreset");
        reset = 1'b0;
        repeat (15) tick("resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
